// File: rtl/enemy_sprite_engine.sv
// ============================================================================
//  Module   : enemy_sprite_engine
//  Purpose  : One invader: spawn/march/animate/hit-test and sprite rendering
//             through an external 1-cycle-latency sprite ROM.
//  Options  : ENEMY_EXPLODE_EN adds an EXPLODE state showing the explosion image.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module enemy_sprite_engine #(
  parameter int SPRITE_W      = 50,
  parameter int SPRITE_H      = 50,
  parameter int NUM_FRAMES    = 2,
  parameter int ANIM_TICKS    = 16,
  parameter int STEP_X        = 1,
  parameter int STEP_Y        = 8,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 589,
`ifdef ENEMY_EXPLODE_EN
  parameter int EXPLODE_TICKS = 12,
`endif
  parameter int ROM_AW        = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_tick,
  input  logic              start,
  input  logic [9:0]        init_x,
  input  logic [9:0]        init_y,
  input  logic              dir_x,
  input  logic              step_down,
  input  logic              shot_valid,
  input  logic [9:0]        shot_x,
  input  logic [9:0]        shot_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic              enemy_on,
  output logic [7:0]        enemy_R,
  output logic [7:0]        enemy_G,
  output logic [7:0]        enemy_B,
  output logic [9:0]        pos_x,
  output logic [9:0]        pos_y,
  output logic              alive,
  output logic              edge_hit,
  output logic              hit
);

  localparam int ACW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
  localparam int FW  = $clog2(NUM_FRAMES + 1);
  localparam logic [ROM_AW-1:0] c_FRAME_SZ = ROM_AW'(SPRITE_W * SPRITE_H);
  localparam logic [ROM_AW-1:0] c_ROW_SZ   = ROM_AW'(SPRITE_W);
  localparam logic [9:0]        c_Y_LIMIT  = 10'(1023 - SPRITE_H);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ALIVE   = 2'd1,
    S_EXPLODE = 2'd2,
    S_DEAD    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [9:0]        r_pos_x;
  logic [9:0]        r_pos_y;
  logic [ACW-1:0]    r_anim_cnt;
  logic [FW-1:0]     r_frm;
  logic [ROM_AW-1:0] r_rom_addr;
  logic              r_in_box_d;
  logic              r_hit;

  logic              w_alive;
  logic              w_render;
  logic              w_load;
  logic              w_kill;
  logic              w_move;
  logic              w_draw_in;
  logic [FW-1:0]     w_frm_sel;
  logic [10:0]       w_x_inc;
  logic [10:0]       w_y_inc;
  logic [9:0]        w_x_right;
  logic [9:0]        w_x_left;
  logic [9:0]        w_y_down;
  logic [9:0]        w_dx;
  logic [9:0]        w_dy;
  logic [ROM_AW-1:0] w_addr;

  // Compares run at 11 bits so a box near the 1023 edge never wraps to 0.
  function automatic logic f_in_box(input logic [9:0] px, input logic [9:0] py,
                                    input logic [9:0] ox, input logic [9:0] oy);
    logic [10:0] x, y, x0, y0;
    x  = {1'b0, px};
    y  = {1'b0, py};
    x0 = {1'b0, ox};
    y0 = {1'b0, oy};
    return (x >= x0) && (x < x0 + 11'(SPRITE_W)) &&
           (y >= y0) && (y < y0 + 11'(SPRITE_H));
  endfunction

  assign w_alive  = (r_state == S_ALIVE);
  assign w_render = (r_state == S_ALIVE) || (r_state == S_EXPLODE);
  assign w_load   = start && ((r_state == S_IDLE) || (r_state == S_DEAD));
  assign w_kill   = w_alive && shot_valid && f_in_box(shot_x, shot_y, r_pos_x, r_pos_y);
  assign w_move   = w_alive && frame_tick && !w_kill;

  assign w_x_inc   = {1'b0, r_pos_x} + 11'(STEP_X);
  assign w_y_inc   = {1'b0, r_pos_y} + 11'(STEP_Y);
  assign w_x_right = (w_x_inc > 11'(X_MAX)) ? 10'(X_MAX) : w_x_inc[9:0];
  assign w_x_left  = ({1'b0, r_pos_x} < 11'(X_MIN + STEP_X)) ? 10'(X_MIN)
                                                             : r_pos_x - 10'(STEP_X);
  assign w_y_down  = (w_y_inc > {1'b0, c_Y_LIMIT}) ? c_Y_LIMIT : w_y_inc[9:0];

`ifdef ENEMY_EXPLODE_EN
  localparam int ECW = (EXPLODE_TICKS > 1) ? $clog2(EXPLODE_TICKS) : 1;

  logic [ECW-1:0] r_expl_cnt;
  logic           w_expl_done;

  assign w_expl_done = frame_tick && (r_expl_cnt == ECW'(EXPLODE_TICKS - 1));
  assign w_frm_sel   = (r_state == S_EXPLODE) ? FW'(NUM_FRAMES) : r_frm;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_expl_cnt <= '0;
    end else if (r_state != S_EXPLODE) begin
      r_expl_cnt <= '0;
    end else if (frame_tick) begin
      r_expl_cnt <= r_expl_cnt + 1'b1;
    end
  end
`else
  assign w_frm_sel = r_frm;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DEAD: begin
        if (start) w_state_nxt = S_ALIVE;
      end
      S_ALIVE: begin
`ifdef ENEMY_EXPLODE_EN
        if (w_kill) w_state_nxt = S_EXPLODE;
`else
        if (w_kill) w_state_nxt = S_DEAD;
`endif
      end
      S_EXPLODE: begin
`ifdef ENEMY_EXPLODE_EN
        if (w_expl_done) w_state_nxt = S_DEAD;
`else
        w_state_nxt = S_DEAD;
`endif
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pos_x <= '0;
      r_pos_y <= '0;
    end else if (w_load) begin
      r_pos_x <= init_x;
      r_pos_y <= init_y;
    end else if (w_move) begin
      if (step_down) begin
        r_pos_y <= w_y_down;
      end else begin
        r_pos_x <= dir_x ? w_x_right : w_x_left;
      end
    end
  end

  // A fresh spawn always begins its march animation on frame 0.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_anim_cnt <= '0;
      r_frm      <= '0;
    end else if (w_load) begin
      r_anim_cnt <= '0;
      r_frm      <= '0;
    end else if (w_move) begin
      if (r_anim_cnt == ACW'(ANIM_TICKS - 1)) begin
        r_anim_cnt <= '0;
        r_frm      <= (r_frm == FW'(NUM_FRAMES - 1)) ? '0 : r_frm + 1'b1;
      end else begin
        r_anim_cnt <= r_anim_cnt + 1'b1;
      end
    end
  end

  assign w_draw_in = w_render && f_in_box(DrawX, DrawY, r_pos_x, r_pos_y);
  assign w_dx      = DrawX - r_pos_x;
  assign w_dy      = DrawY - r_pos_y;
  assign w_addr    = ROM_AW'(w_frm_sel) * c_FRAME_SZ + ROM_AW'(w_dy) * c_ROW_SZ
                   + ROM_AW'(w_dx);

  // Address only moves inside the box; the in-box flag tracks the ROM latency.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rom_addr <= '0;
      r_in_box_d <= 1'b0;
      r_hit      <= 1'b0;
    end else begin
      if (w_draw_in) r_rom_addr <= w_addr;
      r_in_box_d <= w_draw_in;
      r_hit      <= w_kill;
    end
  end

  assign rom_addr = r_rom_addr;
  assign enemy_on = r_in_box_d && w_render && (rom_data != 24'h000000);
  assign enemy_R  = enemy_on ? rom_data[23:16] : 8'h00;
  assign enemy_G  = enemy_on ? rom_data[15:8]  : 8'h00;
  assign enemy_B  = enemy_on ? rom_data[7:0]   : 8'h00;
  assign pos_x    = r_pos_x;
  assign pos_y    = r_pos_y;
  assign alive    = w_alive;
  assign edge_hit = w_alive && ((r_pos_x == 10'(X_MIN)) || (r_pos_x == 10'(X_MAX)));
  assign hit      = r_hit;

endmodule

`default_nettype wire

// File: tb/tb_enemy_sprite_engine.sv
// ============================================================================
//  Module   : tb_enemy_sprite_engine
//  Purpose  : Directed self-checking bench for enemy_sprite_engine.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_enemy_sprite_engine;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_tick, start, dir_x, step_down, shot_valid;
  logic [9:0]  init_x, init_y, shot_x, shot_y, DrawX, DrawY;
  logic [15:0] rom_addr;
  logic [23:0] rom_data;
  logic        enemy_on, alive, edge_hit, hit;
  logic [7:0]  enemy_R, enemy_G, enemy_B;
  logic [9:0]  pos_x, pos_y;

  int n_checks = 0;
  int n_err    = 0;

  enemy_sprite_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start(start),
    .init_x(init_x), .init_y(init_y), .dir_x(dir_x), .step_down(step_down),
    .shot_valid(shot_valid), .shot_x(shot_x), .shot_y(shot_y),
    .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr), .rom_data(rom_data),
    .enemy_on(enemy_on), .enemy_R(enemy_R), .enemy_G(enemy_G), .enemy_B(enemy_B),
    .pos_x(pos_x), .pos_y(pos_y), .alive(alive), .edge_hit(edge_hit), .hit(hit)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask

  task automatic spawn(input logic [9:0] x, input logic [9:0] y);
    init_x = x;
    init_y = y;
    start  = 1'b1;
    cyc();
    start  = 1'b0;
  endtask

  task automatic kill(input logic [9:0] x, input logic [9:0] y);
    shot_x     = x;
    shot_y     = y;
    shot_valid = 1'b1;
    cyc();
    shot_valid = 1'b0;
    check("kill_hit", hit, 1'b1);
    check("kill_alive", alive, 1'b0);
`ifdef ENEMY_EXPLODE_EN
    repeat (12) tick();
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 1'b0; frame_tick = 1'b0; start = 1'b0; dir_x = 1'b0; step_down = 1'b0;
    shot_valid = 1'b0; init_x = '0; init_y = '0; shot_x = '0; shot_y = '0;
    DrawX = '0; DrawY = '0; rom_data = '0;
    repeat (2) cyc();
    check("rst_addr", rom_addr, 16'd0);
    check("rst_alive", alive, 1'b0);
    check("rst_pos", {pos_x, pos_y}, 20'd0);
    check("rst_edge", edge_hit, 1'b0);
    check("rst_on", enemy_on, 1'b0);
    Reset_n = 1'b1;
    cyc();

    // spawn, draw a pixel, then async reset mid-scan
    spawn(10'd100, 10'd40);
    check("spawn1_pos", {pos_x, pos_y}, {10'd100, 10'd40});
    check("spawn1_alive", alive, 1'b1);
    DrawX = 10'd110; DrawY = 10'd45;
    cyc();
    check("draw_addr260", rom_addr, 16'd260);
    rom_data = 24'h123456;
    #1;
    check("draw_on", enemy_on, 1'b1);
    #1 Reset_n = 1'b0;
    #1;
    check("async_addr", rom_addr, 16'd0);
    check("async_pos", {pos_x, pos_y}, 20'd0);
    check("async_alive", alive, 1'b0);
    check("async_on", enemy_on, 1'b0);
    check("async_G", enemy_G, 8'h00);
    #1 Reset_n = 1'b1;
    cyc();
    spawn(10'd100, 10'd40);
    check("spawn2_pos", {pos_x, pos_y}, {10'd100, 10'd40});
    check("spawn2_alive", alive, 1'b1);

    // rendering
    rom_data = 24'h0; DrawX = 10'd101; DrawY = 10'd40;
    cyc();
    check("addr1", rom_addr, 16'd1);
    DrawX = 10'd100;
    cyc();
    check("addr0", rom_addr, 16'd0);
    rom_data = 24'hFF00FF;
    #1;
    check("pix_on", enemy_on, 1'b1);
    check("pix_rgb", {enemy_R, enemy_G, enemy_B}, 24'hFF00FF);
    rom_data = 24'h0;
    #1;
    check("pix_black", enemy_on, 1'b0);
    check("pix_black_R", enemy_R, 8'h00);
    DrawX = 10'd149; DrawY = 10'd89;
    cyc();
    check("addr_corner", rom_addr, 16'd2499);
    rom_data = 24'hFF00FF; DrawX = 10'd150;
    cyc();
    check("right_out_on", enemy_on, 1'b0);
    check("right_out_addr", rom_addr, 16'd2499);
    DrawX = 10'd100; DrawY = 10'd90;
    cyc();
    check("below_out_on", enemy_on, 1'b0);

    // shot misses just outside the box
    shot_valid = 1'b1; shot_x = 10'd150; shot_y = 10'd40;
    cyc();
    check("miss_right", hit, 1'b0);
    shot_x = 10'd100; shot_y = 10'd90;
    cyc();
    check("miss_below", hit, 1'b0);
    shot_x = 10'd99; shot_y = 10'd40;
    cyc();
    check("miss_left", hit, 1'b0);
    check("miss_alive", alive, 1'b1);

    // kill coincident with frame_tick: no move
    dir_x = 1'b1; step_down = 1'b0; shot_x = 10'd149; shot_y = 10'd89; frame_tick = 1'b1;
    cyc();
    shot_valid = 1'b0; frame_tick = 1'b0;
    check("kill_pulse", hit, 1'b1);
    check("kill_dead", alive, 1'b0);
    check("kill_nomove", {pos_x, pos_y}, {10'd100, 10'd40});
    DrawX = 10'd100; DrawY = 10'd40;
    cyc();
    check("hit_one_clk", hit, 1'b0);
`ifdef ENEMY_EXPLODE_EN
    check("expl_addr", rom_addr, 16'd5000);
    check("expl_on", enemy_on, 1'b1);
    repeat (11) tick();
    shot_valid = 1'b1; shot_x = 10'd100; shot_y = 10'd40;
    cyc();
    shot_valid = 1'b0;
    check("expl_shot_ignored", hit, 1'b0);
    spawn(10'd200, 10'd200);
    check("expl_start_ignored", pos_x, 10'd100);
    check("expl_alive0", alive, 1'b0);
    tick();
`else
    check("dead_on", enemy_on, 1'b0);
    check("dead_addr_hold", rom_addr, 16'd2499);
`endif

    // step down
    spawn(10'd300, 10'd40);
    check("spawn3_pos", {pos_x, pos_y}, {10'd300, 10'd40});
    step_down = 1'b1;
    tick();
    check("step_down", {pos_x, pos_y}, {10'd300, 10'd48});
    step_down = 1'b0; dir_x = 1'b1;
    tick();
    check("march_right", pos_x, 10'd301);
    kill(10'd301, 10'd48);

    // right edge clamp
    spawn(10'd588, 10'd40);
    check("edge_before", edge_hit, 1'b0);
    dir_x = 1'b1;
    tick();
    check("clamp1", pos_x, 10'd589);
    check("edge1", edge_hit, 1'b1);
    tick();
    check("clamp2", pos_x, 10'd589);
    tick();
    check("clamp3", pos_x, 10'd589);
    check("edge3", edge_hit, 1'b1);
    kill(10'd598, 10'd50);

    // animation frame advance over 32 ticks
    spawn(10'd100, 10'd40);
    dir_x = 1'b0;
    repeat (15) tick();
    DrawX = 10'd85; DrawY = 10'd40;
    cyc();
    check("anim15_pos", pos_x, 10'd85);
    check("anim15_addr", rom_addr, 16'd0);
    tick();
    DrawX = 10'd84;
    cyc();
    check("anim16_addr", rom_addr, 16'd2500);
    repeat (16) tick();
    DrawX = 10'd68;
    cyc();
    check("anim32_pos", pos_x, 10'd68);
    check("anim32_addr", rom_addr, 16'd0);
    kill(10'd68, 10'd40);

    // bottom saturation and left clamp
    spawn(10'd1, 10'd968);
    step_down = 1'b1;
    tick();
    check("ysat1", pos_y, 10'd973);
    tick();
    check("ysat2", pos_y, 10'd973);
    step_down = 1'b0; dir_x = 1'b0;
    tick();
    check("left_clamp1", pos_x, 10'd0);
    check("left_edge", edge_hit, 1'b1);
    tick();
    check("left_clamp2", pos_x, 10'd0);
    check("final_alive", alive, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
